// File: rtl/dual_fetch_unit_pkg.sv
// Shared constants and types for the dual-issue fetch stage.
//   - PC/instruction widths, fetch width and PC step between the two slots
//   - fetch_entry_t: one queued instruction pair {pc0, instr0, pc1, instr1}
//   - align_pc(): forces a fetch PC onto a word boundary
package dual_fetch_unit_pkg;

  localparam int unsigned InstrW     = 32;
  localparam int unsigned PcW        = 32;
  localparam int unsigned FetchWidth = 2;
  localparam logic [PcW-1:0] PcStep  = 32'd4;
  localparam int unsigned EntryW     = FetchWidth * (PcW + InstrW);

  // Slot0 occupies the upper half of an entry, slot1 the lower half.
  typedef struct packed {
    logic [PcW-1:0]    pc0;
    logic [InstrW-1:0] instr0;
    logic [PcW-1:0]    pc1;
    logic [InstrW-1:0] instr1;
  } fetch_entry_t;

  function automatic logic [PcW-1:0] align_pc(input logic [PcW-1:0] pc);
    return {pc[PcW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dual_fetch_unit_fetch_queue.sv
// fetch_queue: circular-buffer FIFO holding fetched instruction pairs.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (empties the queue)
//   push, pop        enqueue wdata / dequeue head; pop when empty is ignored,
//                    push when full is only taken together with a pop
//   flush            empties the queue; wins over push and pop
//   wdata, rdata     entry in / head entry out (rdata is zero while empty)
//   full, empty      occupancy flags
// Depth must be a power of two so the pointers wrap naturally.
module dual_fetch_unit_fetch_queue #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t DepthCnt = cnt_t'(Depth);

  logic [Width-1:0] mem_q [Depth];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && (!full || pop_ok) && !flush;

  // Head is forced to zero while empty so stale data never reaches decode.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (push_ok && !pop_ok) begin
        count_d = count_q + cnt_t'(1);
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the read path is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dual_fetch_unit.sv
// dual_fetch_unit: dual-issue fetch stage between the branch predictor and decode.
// Owns the fetch PC, presents {pc, pc+4} to the predictor and instruction memory,
// and queues fetched pairs toward decode. Obeys the predictor's pcnext and clrbp.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   originalpc[63:0]           {slot0 pc, slot1 pc} to the predictor
//   pcnext, clrbp              predictor next fetch PC and mispredict flush
//   imem_addr, imem_rdata0/1   instruction memory address (slot0) and read data
//   dec_valid, dec_ready       queue head handshake toward decode
//   dec_pc0/1, dec_instr0/1    queue head contents
// Optional (macro FETCH_PERF_CNT_EN):
//   perf_flush_cnt, perf_stall_cnt  saturating flush and stall event counters
module dual_fetch_unit
  import dual_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] originalpc,
  input  logic [31:0] pcnext,
  input  logic        clrbp,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata0,
  input  logic [31:0] imem_rdata1,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc0,
  output logic [31:0] dec_instr0,
  output logic [31:0] dec_pc1,
  output logic [31:0] dec_instr1
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  logic [PcW-1:0]    pc_q, pc_d, pc_plus4;
  logic              q_full, q_empty;
  logic              push, pop;
  fetch_entry_t      wentry, head;
  logic [EntryW-1:0] q_rdata;

  assign pc_plus4   = pc_q + PcStep;
  assign originalpc = {pc_q, pc_plus4};
  assign imem_addr  = pc_q;

  // A flush cancels both the pop credit and the enqueue of the current pair.
  assign dec_valid = !q_empty;
  assign pop       = dec_valid && dec_ready && !clrbp;
  assign push      = (!q_full || pop) && !clrbp;

  assign wentry = '{pc0: pc_q, instr0: imem_rdata0, pc1: pc_plus4, instr1: imem_rdata1};

  dual_fetch_unit_fetch_queue #(
    .Depth (QDEPTH),
    .Width (EntryW)
  ) u_fetch_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (clrbp),
    .wdata (wentry),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

  assign head       = fetch_entry_t'(q_rdata);
  assign dec_pc0    = head.pc0;
  assign dec_instr0 = head.instr0;
  assign dec_pc1    = head.pc1;
  assign dec_instr1 = head.instr1;

  // PC follows the predictor whenever the current pair is consumed or on a flush;
  // otherwise the queue is full and fetch stalls on the same pair.
  always_comb begin
    pc_d = pc_q;
    if (clrbp || push) pc_d = align_pc(pcnext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= align_pc(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (clrbp && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
    if (q_full && !pop && !clrbp && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_flush_cnt = flush_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Self-checking bench for dual_fetch_unit. A queue-based reference model tracks the
// fetch PC, the decode queue and the perf counters (when FETCH_PERF_CNT_EN is set).
module tb_dual_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned QDepth  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] originalpc;
  logic [31:0] pcnext;
  logic        clrbp;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata0, imem_rdata1;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc0, dec_instr0, dec_pc1, dec_instr1;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_flush_cnt, perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Synthetic instruction memory: each word is a scrambled copy of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  assign imem_rdata0 = mem_word(imem_addr);
  assign imem_rdata1 = mem_word(imem_addr + 32'd4);

  dual_fetch_unit #(
    .RESET_PC (ResetPc),
    .QDEPTH   (QDepth)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .originalpc     (originalpc),
    .pcnext         (pcnext),
    .clrbp          (clrbp),
    .imem_addr      (imem_addr),
    .imem_rdata0    (imem_rdata0),
    .imem_rdata1    (imem_rdata1),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc0        (dec_pc0),
    .dec_instr0     (dec_instr0),
    .dec_pc1        (dec_pc1),
    .dec_instr1     (dec_instr1)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_flush_cnt (perf_flush_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc0;
    logic [31:0] i0;
    logic [31:0] pc1;
    logic [31:0] i1;
  } ent_t;

  logic [31:0] m_pc;
  ent_t        mq[$];
  logic [31:0] m_flush;
  logic [31:0] m_stall;

  task automatic model_reset();
    m_pc    = ResetPc;
    mq.delete();
    m_flush = '0;
    m_stall = '0;
  endtask

  // Advance the model with the inputs currently driven, then take one clock edge.
  task automatic tick();
    ent_t e;
    int   occ;
    bit   pop_m, full_m;
    occ = mq.size();
    if (clrbp) begin
      mq.delete();
      m_pc = pcnext & 32'hFFFF_FFFC;
      if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
    end else begin
      full_m = (occ == QDepth);
      pop_m  = (occ > 0) && dec_ready;
      if (full_m && !pop_m && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (pop_m) void'(mq.pop_front());
      if (!full_m || pop_m) begin
        e.pc0 = m_pc;
        e.i0  = mem_word(m_pc);
        e.pc1 = m_pc + 32'd4;
        e.i1  = mem_word(m_pc + 32'd4);
        mq.push_back(e);
        m_pc = pcnext & 32'hFFFF_FFFC;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    clrbp     = 1'b0;
    dec_ready = 1'b0;
    pcnext    = '0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    clrbp     = 1'b0;
    dec_ready = 1'b0;
    pcnext    = '0;
    model_reset();
    #2;
    n_checks++;
    if (originalpc !== {ResetPc, ResetPc + 32'd4}) begin
      n_fail++;
      $display("FAIL reset_originalpc got %h want %h", originalpc, {ResetPc, ResetPc + 32'd4});
    end
    n_checks++;
    if (imem_addr !== ResetPc) begin
      n_fail++;
      $display("FAIL reset_imem_addr got %h want %h", imem_addr, ResetPc);
    end
    n_checks++;
    if (dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dec_valid got %b want 0", dec_valid);
    end
    n_checks++;
    if ({dec_pc0, dec_instr0, dec_pc1, dec_instr1} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_dec_data got %h %h %h %h want all zero",
               dec_pc0, dec_instr0, dec_pc1, dec_instr1);
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    dec_ready = 1'b1;
    pcnext    = m_pc + 32'd8;
    tick();
    n_checks++;
    if (originalpc !== {32'd8, 32'd12}) begin
      n_fail++;
      $display("FAIL seq_pc1 got %h want %h", originalpc, {32'd8, 32'd12});
    end
    n_checks++;
    if (dec_valid !== 1'b1 || dec_pc0 !== 32'd0 || dec_pc1 !== 32'd4 ||
        dec_instr0 !== mem_word(32'd0) || dec_instr1 !== mem_word(32'd4)) begin
      n_fail++;
      $display("FAIL seq_head1 got v=%b %h %h %h %h want v=1 pc0=0 pc1=4",
               dec_valid, dec_pc0, dec_instr0, dec_pc1, dec_instr1);
    end
    pcnext = m_pc + 32'd8;
    tick();
    n_checks++;
    if (originalpc !== {32'd16, 32'd20}) begin
      n_fail++;
      $display("FAIL seq_pc2 got %h want %h", originalpc, {32'd16, 32'd20});
    end
    n_checks++;
    if (dec_valid !== 1'b1 || dec_pc0 !== 32'd8 || dec_instr1 !== mem_word(32'd12)) begin
      n_fail++;
      $display("FAIL seq_head2 got v=%b pc0=%h i1=%h want v=1 pc0=8 i1=%h",
               dec_valid, dec_pc0, dec_instr1, mem_word(32'd12));
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pcnext = m_pc + 32'd8;
      tick();
      n_checks++;
      if (originalpc !== {m_pc, m_pc + 32'd4}) begin
        n_fail++;
        $display("FAIL stall_pc cycle %0d got %h want %h", i, originalpc, {m_pc, m_pc + 32'd4});
      end
    end
    n_checks++;
    if (originalpc !== {32'd32, 32'd36} || dec_pc0 !== 32'd0) begin
      n_fail++;
      $display("FAIL stall_hold got pc=%h head=%h want pc=%h head=0",
               originalpc, dec_pc0, {32'd32, 32'd36});
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_stall_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL stall_cnt got %0d want 2", perf_stall_cnt);
    end
`endif
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_head [3];
    exp_head[0] = 32'd16;
    exp_head[1] = 32'd24;
    exp_head[2] = 32'd32;
    // Queue is full here: pop and push together.
    dec_ready = 1'b1;
    pcnext    = m_pc + 32'd8;
    tick();
    n_checks++;
    if (dec_pc0 !== 32'd8 || originalpc !== {32'd40, 32'd44}) begin
      n_fail++;
      $display("FAIL fullpp_advance got head=%h pc=%h want head=8 pc=%h",
               dec_pc0, originalpc, {32'd40, 32'd44});
    end
    // Still full afterwards: with no pop the PC must hold.
    dec_ready = 1'b0;
    pcnext    = 32'h100;
    tick();
    n_checks++;
    if (originalpc !== {32'd40, 32'd44}) begin
      n_fail++;
      $display("FAIL fullpp_count got pc=%h want %h", originalpc, {32'd40, 32'd44});
    end
    dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pcnext = m_pc + 32'd8;
      tick();
      n_checks++;
      if (dec_pc0 !== exp_head[i] || dec_instr0 !== mem_word(exp_head[i])) begin
        n_fail++;
        $display("FAIL fullpp_drain %0d got %h/%h want %h/%h", i, dec_pc0, dec_instr0,
                 exp_head[i], mem_word(exp_head[i]));
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pcnext = m_pc + 32'd8;
      tick();
    end
    n_checks++;
    if (dec_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_prefill got dec_valid=%b want 1", dec_valid);
    end
    clrbp  = 1'b1;
    pcnext = 32'h40;
    tick();
    clrbp = 1'b0;
    n_checks++;
    if (dec_valid !== 1'b0 || originalpc !== {32'h40, 32'h44} || dec_pc0 !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_state got v=%b pc=%h head=%h want v=0 pc=%h head=0",
               dec_valid, originalpc, dec_pc0, {32'h40, 32'h44});
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_flush_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL flush_cnt got %0d want 1", perf_flush_cnt);
    end
`endif
  endtask

  task automatic test_wrap_align();
    dec_ready = 1'b1;
    pcnext    = 32'hFFFF_FFFF;
    tick();
    n_checks++;
    if (originalpc !== {32'hFFFF_FFFC, 32'h0000_0000}) begin
      n_fail++;
      $display("FAIL wrap_pc got %h want %h", originalpc, {32'hFFFF_FFFC, 32'h0000_0000});
    end
    pcnext = 32'h0000_0013;
    tick();
    n_checks++;
    if (originalpc !== {32'h10, 32'h14}) begin
      n_fail++;
      $display("FAIL align_pc got %h want %h", originalpc, {32'h10, 32'h14});
    end
    n_checks++;
    if (dec_pc0 !== 32'hFFFF_FFFC || dec_pc1 !== 32'h0 || dec_instr1 !== mem_word(32'h0)) begin
      n_fail++;
      $display("FAIL wrap_entry got %h %h %h want FFFFFFFC 0 %h",
               dec_pc0, dec_pc1, dec_instr1, mem_word(32'h0));
    end
  endtask

  task automatic test_random();
    ent_t h;
    bit   ev;
    for (int i = 0; i < 300; i++) begin
      dec_ready = ($urandom_range(0, 99) < 45);
      clrbp     = ($urandom_range(0, 15) == 0);
      pcnext    = ($urandom_range(0, 3) == 0) ? $urandom() : m_pc + 32'd8;
      tick();
      ev = (mq.size() != 0);
      if (ev) begin
        h = mq[0];
      end else begin
        h = '{default: '0};
      end
      n_checks++;
      if (originalpc !== {m_pc, m_pc + 32'd4} || imem_addr !== m_pc) begin
        n_fail++;
        $display("FAIL rand_pc cycle %0d got %h/%h want %h", i, originalpc, imem_addr,
                 {m_pc, m_pc + 32'd4});
      end
      n_checks++;
      if (dec_valid !== ev || dec_pc0 !== h.pc0 || dec_instr0 !== h.i0 ||
          dec_pc1 !== h.pc1 || dec_instr1 !== h.i1) begin
        n_fail++;
        $display("FAIL rand_head cycle %0d got v=%b %h %h %h %h want v=%b %h %h %h %h", i,
                 dec_valid, dec_pc0, dec_instr0, dec_pc1, dec_instr1,
                 ev, h.pc0, h.i0, h.pc1, h.i1);
      end
`ifdef FETCH_PERF_CNT_EN
      n_checks++;
      if (perf_flush_cnt !== m_flush || perf_stall_cnt !== m_stall) begin
        n_fail++;
        $display("FAIL rand_perf cycle %0d got %0d/%0d want %0d/%0d", i,
                 perf_flush_cnt, perf_stall_cnt, m_flush, m_stall);
      end
`endif
    end
    clrbp = 1'b0;
  endtask

  task automatic test_async_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pcnext = m_pc + 32'd8;
      tick();
    end
    n_checks++;
    if (dec_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_prefill got dec_valid=%b want 1", dec_valid);
    end
    // Mid-cycle, well away from any clock edge.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dec_valid !== 1'b0 || originalpc !== {ResetPc, ResetPc + 32'd4} ||
        imem_addr !== ResetPc) begin
      n_fail++;
      $display("FAIL arst_immediate got v=%b pc=%h addr=%h want v=0 pc=%h addr=%h",
               dec_valid, originalpc, imem_addr, {ResetPc, ResetPc + 32'd4}, ResetPc);
    end
    #1;
    rst_n     = 1'b1;
    dec_ready = 1'b1;
    pcnext    = m_pc + 32'd8;
    tick();
    n_checks++;
    if (dec_valid !== 1'b1 || dec_pc0 !== ResetPc) begin
      n_fail++;
      $display("FAIL arst_recover got v=%b head=%h want v=1 head=%h", dec_valid, dec_pc0, ResetPc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_full_push_pop();
    test_flush();
    test_wrap_align();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
